// File: rtl/nco_sweep_sequencer_if.sv
// Sweep configuration/control from the host and NCO byte-load/status back from the sequencer.
// master = host side, slave = sequencer side.
interface nco_sweep_sequencer_if #(
   parameter int STEPS_W = 8,
   parameter int DWELL_W = 16
);
   logic               start;
   logic               abort;
   logic               hold;
   logic [1:0]         mode;
   logic [15:0]        fcwStart;
   logic [15:0]        fcwStep;
   logic [STEPS_W-1:0] numSteps;
   logic [DWELL_W-1:0] dwellCycles;
   logic               loop;

   logic               ncoEnable;
   logic [7:0]         ncoData;
   logic [7:0]         ncoCtrl;
   logic               busy;
   logic               done;
   logic [STEPS_W-1:0] stepIdx;

   modport master (
      output start, abort, hold, mode, fcwStart, fcwStep, numSteps, dwellCycles, loop,
      input  ncoEnable, ncoData, ncoCtrl, busy, done, stepIdx
   );

   modport slave (
      input  start, abort, hold, mode, fcwStart, fcwStep, numSteps, dwellCycles, loop,
      output ncoEnable, ncoData, ncoCtrl, busy, done, stepIdx
   );
endinterface

// File: rtl/nco_sweep_sequencer.sv
// Linear FCW sweep driving the NCO byte-load port; outputs registered, one cycle after the deciding edge.
// hold freezes every register and drops ncoEnable; abort returns to IDLE on the next edge.
module nco_sweep_sequencer #(
   parameter int STEPS_W = 8,
   parameter int DWELL_W = 16
) (
   input logic clk,
   input logic rst,
   nco_sweep_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD_LO, LOAD_HI, DWELL} state_t;

   localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
   localparam logic [STEPS_W-1:0] STEP_ONE  = STEPS_W'(1);

   state_t             state, stateN;
   logic [15:0]        curFcw, curFcwN;
   logic [15:0]        fcwStartL, fcwStartLN;
   logic [15:0]        fcwStepL, fcwStepLN;
   logic [STEPS_W-1:0] numStepsL, numStepsLN;
   logic [DWELL_W-1:0] dwellL, dwellLN;
   logic [DWELL_W-1:0] dwellCnt, dwellCntN;
   logic [1:0]         modeL, modeLN;
   logic               loopL, loopLN;
   logic [STEPS_W-1:0] stepIdxQ, stepIdxN;
   logic               ncoEnableQ, ncoEnableN;
   logic [7:0]         ncoDataQ, ncoDataN;
   logic [7:0]         ncoCtrlQ, ncoCtrlN;
   logic               busyQ, busyN;
   logic               doneQ, doneN;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         curFcw     <= '0;
         fcwStartL  <= '0;
         fcwStepL   <= '0;
         numStepsL  <= '0;
         dwellL     <= '0;
         dwellCnt   <= '0;
         modeL      <= '0;
         loopL      <= 1'b0;
         stepIdxQ   <= '0;
         ncoEnableQ <= 1'b0;
         ncoDataQ   <= '0;
         ncoCtrlQ   <= '0;
         busyQ      <= 1'b0;
         doneQ      <= 1'b0;
      end else begin
         state      <= stateN;
         curFcw     <= curFcwN;
         fcwStartL  <= fcwStartLN;
         fcwStepL   <= fcwStepLN;
         numStepsL  <= numStepsLN;
         dwellL     <= dwellLN;
         dwellCnt   <= dwellCntN;
         modeL      <= modeLN;
         loopL      <= loopLN;
         stepIdxQ   <= stepIdxN;
         ncoEnableQ <= ncoEnableN;
         ncoDataQ   <= ncoDataN;
         ncoCtrlQ   <= ncoCtrlN;
         busyQ      <= busyN;
         doneQ      <= doneN;
      end
   end

   always_comb begin
      stateN     = state;
      curFcwN    = curFcw;
      fcwStartLN = fcwStartL;
      fcwStepLN  = fcwStepL;
      numStepsLN = numStepsL;
      dwellLN    = dwellL;
      dwellCntN  = dwellCnt;
      modeLN     = modeL;
      loopLN     = loopL;
      stepIdxN   = stepIdxQ;
      ncoEnableN = ncoEnableQ;
      ncoDataN   = ncoDataQ;
      ncoCtrlN   = ncoCtrlQ;
      busyN      = busyQ;
      doneN      = 1'b0;

      if (bus.abort) begin
         stateN     = IDLE;
         stepIdxN   = '0;
         ncoEnableN = 1'b1;
         ncoDataN   = '0;
         ncoCtrlN   = '0;
         busyN      = 1'b0;
      end else if (bus.hold && !(state == IDLE && bus.start)) begin
         // Frozen cycle: the NCO already saw these outputs once, so it just pauses.
         ncoEnableN = 1'b0;
      end else begin
         ncoEnableN = !bus.hold;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  fcwStartLN = bus.fcwStart;
                  fcwStepLN  = bus.fcwStep;
                  numStepsLN = bus.numSteps;
                  dwellLN    = bus.dwellCycles;
                  modeLN     = bus.mode;
                  loopLN     = bus.loop;
                  curFcwN    = bus.fcwStart;
                  stepIdxN   = '0;
                  stateN     = LOAD_LO;
               end
            end
            LOAD_LO: stateN = LOAD_HI;
            LOAD_HI: begin
               dwellCntN = (dwellL == '0) ? DWELL_ONE : dwellL;
               stateN    = DWELL;
            end
            DWELL: begin
               if (dwellCnt <= DWELL_ONE) begin
                  if (stepIdxQ != numStepsL) begin
                     curFcwN  = curFcw + fcwStepL;
                     stepIdxN = stepIdxQ + STEP_ONE;
                     stateN   = LOAD_LO;
                  end else if (loopL) begin
                     curFcwN  = fcwStartL;
                     stepIdxN = '0;
                     stateN   = LOAD_LO;
                  end else begin
                     stepIdxN = '0;
                     doneN    = 1'b1;
                     stateN   = IDLE;
                  end
               end else begin
                  dwellCntN = dwellCnt - DWELL_ONE;
               end
            end
            default: stateN = IDLE;
         endcase

         // Outputs follow the state being entered so both change on the same edge.
         unique case (stateN)
            IDLE: begin
               ncoDataN = '0;
               ncoCtrlN = '0;
            end
            LOAD_LO: begin
               ncoDataN = curFcwN[7:0];
               ncoCtrlN = {4'b0, 2'b01, modeLN};
            end
            LOAD_HI: begin
               ncoDataN = curFcwN[15:8];
               ncoCtrlN = {4'b0, 2'b10, modeLN};
            end
            DWELL:   ncoCtrlN = {6'b0, modeLN};
            default: ncoCtrlN = '0;
         endcase
         busyN = (stateN != IDLE);
      end
   end

   assign bus.ncoEnable = ncoEnableQ;
   assign bus.ncoData   = ncoDataQ;
   assign bus.ncoCtrl   = ncoCtrlQ;
   assign bus.busy      = busyQ;
   assign bus.done      = doneQ;
   assign bus.stepIdx   = stepIdxQ;
endmodule

// File: tb/tb_nco_sweep_sequencer.sv
// Directed bench for nco_sweep_sequencer: per-cycle output checks against hand-computed byte sequences.
module tb_nco_sweep_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   nco_sweep_sequencer_if #(.STEPS_W(8), .DWELL_W(16)) bus ();

   nco_sweep_sequencer #(.STEPS_W(8), .DWELL_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOut(input string tag, input logic en, input logic [7:0] data,
                           input logic [7:0] ctrl, input logic busy, input logic done,
                           input logic [7:0] step);
      checkVal({tag, ".en"},   32'(bus.ncoEnable), 32'(en));
      checkVal({tag, ".data"}, 32'(bus.ncoData),   32'(data));
      checkVal({tag, ".ctrl"}, 32'(bus.ncoCtrl),   32'(ctrl));
      checkVal({tag, ".busy"}, 32'(bus.busy),      32'(busy));
      checkVal({tag, ".done"}, 32'(bus.done),      32'(done));
      checkVal({tag, ".step"}, 32'(bus.stepIdx),   32'(step));
   endtask

   task automatic checkIdle(input string tag, input logic done);
      checkOut(tag, 1'b1, 8'h00, 8'h00, 1'b0, done, 8'd0);
   endtask

   // One frequency: LOAD_LO, LOAD_HI, then dwell cycles; leaves the bench on the next frequency's first cycle.
   task automatic checkFreq(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] cLo, input logic [7:0] cHi, input logic [7:0] cDw,
                            input int dwell, input logic [7:0] step);
      checkOut({tag, ".lo"}, 1'b1, lo, cLo, 1'b1, 1'b0, step);
      tick();
      checkOut({tag, ".hi"}, 1'b1, hi, cHi, 1'b1, 1'b0, step);
      tick();
      for (int i = 0; i < dwell; i++) begin
         checkOut({tag, ".dw"}, 1'b1, hi, cDw, 1'b1, 1'b0, step);
         tick();
      end
   endtask

   task automatic setCfg(input logic [15:0] fs, input logic [15:0] st, input logic [7:0] n,
                         input logic [15:0] d, input logic [1:0] m, input logic lp);
      bus.fcwStart    = fs;
      bus.fcwStep     = st;
      bus.numSteps    = n;
      bus.dwellCycles = d;
      bus.mode        = m;
      bus.loop        = lp;
   endtask

   task automatic pulseStart();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.hold  = 1'b0;
      setCfg(16'h0000, 16'h0000, 8'd0, 16'd0, 2'd0, 1'b0);

      tick();
      tick();
      checkOut("reset", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
      rst = 1'b0;
      tick();
      checkIdle("idle", 1'b0);

      // Basic sweep; config inputs are scrambled right after start to show they were latched.
      setCfg(16'h0100, 16'h0010, 8'd2, 16'd3, 2'd1, 1'b0);
      pulseStart();
      setCfg(16'hAAAA, 16'h5555, 8'd7, 16'd9, 2'd2, 1'b1);
      checkFreq("basic0", 8'h00, 8'h01, 8'h05, 8'h09, 8'h01, 3, 8'd0);
      checkFreq("basic1", 8'h10, 8'h01, 8'h05, 8'h09, 8'h01, 3, 8'd1);
      checkFreq("basic2", 8'h20, 8'h01, 8'h05, 8'h09, 8'h01, 3, 8'd2);
      checkIdle("basic.end", 1'b1);
      tick();
      checkIdle("basic.post", 1'b0);

      setCfg(16'hFFF0, 16'h0020, 8'd1, 16'd1, 2'd2, 1'b0);
      pulseStart();
      checkFreq("wrap0", 8'hF0, 8'hFF, 8'h06, 8'h0A, 8'h02, 1, 8'd0);
      checkFreq("wrap1", 8'h10, 8'h00, 8'h06, 8'h0A, 8'h02, 1, 8'd1);
      checkIdle("wrap.end", 1'b1);
      tick();

      setCfg(16'h0008, 16'hFFF0, 8'd1, 16'd2, 2'd1, 1'b0);
      pulseStart();
      checkFreq("neg0", 8'h08, 8'h00, 8'h05, 8'h09, 8'h01, 2, 8'd0);
      checkFreq("neg1", 8'hF8, 8'hFF, 8'h05, 8'h09, 8'h01, 2, 8'd1);
      checkIdle("neg.end", 1'b1);
      tick();

      setCfg(16'h1234, 16'h0001, 8'd0, 16'd0, 2'd3, 1'b1);
      pulseStart();
      for (int r = 0; r < 3; r++)
         checkFreq("loop", 8'h34, 8'h12, 8'h07, 8'h0B, 8'h03, 1, 8'd0);
      checkOut("loop.again", 1'b1, 8'h34, 8'h07, 1'b1, 1'b0, 8'd0);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      checkIdle("abort", 1'b0);
      tick();
      checkIdle("abort.post", 1'b0);

      setCfg(16'h0100, 16'h0010, 8'd1, 16'd3, 2'd1, 1'b0);
      pulseStart();
      checkOut("hold.lo", 1'b1, 8'h00, 8'h05, 1'b1, 1'b0, 8'd0);
      tick();
      checkOut("hold.hi", 1'b1, 8'h01, 8'h09, 1'b1, 1'b0, 8'd0);
      tick();
      checkOut("hold.dw1", 1'b1, 8'h01, 8'h01, 1'b1, 1'b0, 8'd0);
      bus.hold = 1'b1;
      for (int h = 0; h < 4; h++) begin
         tick();
         checkOut("hold.frz", 1'b0, 8'h01, 8'h01, 1'b1, 1'b0, 8'd0);
      end
      bus.hold = 1'b0;
      tick();
      checkOut("hold.dw2", 1'b1, 8'h01, 8'h01, 1'b1, 1'b0, 8'd0);
      tick();
      checkOut("hold.dw3", 1'b1, 8'h01, 8'h01, 1'b1, 1'b0, 8'd0);
      tick();
      checkFreq("hold1", 8'h10, 8'h01, 8'h05, 8'h09, 8'h01, 3, 8'd1);
      checkIdle("hold.end", 1'b1);
      tick();

      pulseStart();
      tick();
      checkOut("rstmid.hi", 1'b1, 8'h01, 8'h09, 1'b1, 1'b0, 8'd0);
      rst = 1'b1;
      tick();
      checkOut("rstmid", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd0);
      rst = 1'b0;
      tick();
      checkIdle("rstmid.rel", 1'b0);

      bus.start = 1'b1;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      checkIdle("startabort", 1'b0);
      tick();
      checkIdle("startabort.post", 1'b0);

      setCfg(16'h4321, 16'h0001, 8'd0, 16'd3, 2'd2, 1'b0);
      pulseStart();
      checkOut("busystart.lo", 1'b1, 8'h21, 8'h06, 1'b1, 1'b0, 8'd0);
      tick();
      checkOut("busystart.hi", 1'b1, 8'h43, 8'h0A, 1'b1, 1'b0, 8'd0);
      tick();
      checkOut("busystart.dw1", 1'b1, 8'h43, 8'h02, 1'b1, 1'b0, 8'd0);
      bus.start    = 1'b1;
      bus.fcwStart = 16'h0000;
      tick();
      bus.start = 1'b0;
      checkOut("busystart.dw2", 1'b1, 8'h43, 8'h02, 1'b1, 1'b0, 8'd0);
      tick();
      checkOut("busystart.dw3", 1'b1, 8'h43, 8'h02, 1'b1, 1'b0, 8'd0);
      tick();
      checkIdle("busystart.end", 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
